// File: rtl/cdb_broadcast_arbiter_pkg.sv
// rtl/cdb_broadcast_arbiter_pkg.sv - shared CDB entry type, sizing constants and round-robin helper
package cdb_broadcast_arbiter_pkg;

    localparam int CDB_NUM_FU = 4;
    localparam int ROB_TAG_W  = 5;
    localparam int CDB_DATA_W = 32;

    // Field order follows CDB_PACKET: tag, value, take_branch
    typedef struct packed {
        logic [ROB_TAG_W-1:0]  tag;
        logic [CDB_DATA_W-1:0] value;
        logic                  take_branch;
    } cdb_entry_t;

    function automatic int rr_index(input int base, input int offset, input int n);
        return (base + offset) % n;
    endfunction

endpackage

// File: rtl/cdb_result_fifo.sv
// rtl/cdb_result_fifo.sv - per-FU result FIFO with flush; full/empty from a dedicated count
module cdb_result_fifo
    import cdb_broadcast_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       push,
    input  logic       pop,
    input  logic       flush,
    input  cdb_entry_t din,
    output cdb_entry_t head,
    output logic       empty,
    output logic       full
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    cdb_entry_t      mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic            push_ok, pop_ok;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign push_ok = push && !full && !flush;
    assign pop_ok  = pop && !empty && !flush;
    assign head    = mem_q[rd_ptr_q];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
        end
    end

    // Storage needs no reset: the count alone decides which entries are live
    always_ff @(posedge clock) begin
        if (push_ok) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/cdb_broadcast_arbiter.sv
// rtl/cdb_broadcast_arbiter.sv - round-robin CDB arbiter with registered broadcast; CDB_ARB_STATS_EN adds conflict_cycles
module cdb_broadcast_arbiter
    import cdb_broadcast_arbiter_pkg::*;
#(
    parameter int NUM_FU    = CDB_NUM_FU,
    parameter int BUF_DEPTH = 2,
    parameter int TAG_W     = ROB_TAG_W,
    parameter int DATA_W    = CDB_DATA_W
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     squash,
    input  logic [NUM_FU-1:0]        fu_valid,
    input  logic [NUM_FU*TAG_W-1:0]  fu_tag,
    input  logic [NUM_FU*DATA_W-1:0] fu_value,
    input  logic [NUM_FU-1:0]        fu_take_branch,
    output logic [NUM_FU-1:0]        fu_ready,
    output logic                     cdb_valid,
    output logic [TAG_W-1:0]         cdb_tag,
    output logic [DATA_W-1:0]        cdb_value,
    output logic                     cdb_take_branch
`ifdef CDB_ARB_STATS_EN
    ,
    output logic [31:0]              conflict_cycles
`endif
);

    localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    cdb_entry_t              fifo_in   [NUM_FU];
    cdb_entry_t              fifo_head [NUM_FU];
    logic [NUM_FU-1:0]       fifo_empty, fifo_full, fifo_push, fifo_pop;
    logic [PTR_W-1:0]        rr_ptr_q, rr_ptr_d, grant_idx;
    logic                    grant_valid;
    logic                    cdb_valid_q, cdb_valid_d;
    cdb_entry_t              cdb_entry_q, cdb_entry_d;

    for (genvar i = 0; i < NUM_FU; i++) begin : g_fu
        assign fifo_in[i].tag         = fu_tag[i*TAG_W +: TAG_W];
        assign fifo_in[i].value       = fu_value[i*DATA_W +: DATA_W];
        assign fifo_in[i].take_branch = fu_take_branch[i];
        // Ready comes only from registered state, so there is no grant-to-ready path
        assign fu_ready[i]  = !fifo_full[i];
        assign fifo_push[i] = fu_valid[i] && !fifo_full[i];
        assign fifo_pop[i]  = grant_valid && (grant_idx == PTR_W'(i));

        cdb_result_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
            .clock (clock),
            .reset (reset),
            .push  (fifo_push[i]),
            .pop   (fifo_pop[i]),
            .flush (squash),
            .din   (fifo_in[i]),
            .head  (fifo_head[i]),
            .empty (fifo_empty[i]),
            .full  (fifo_full[i])
        );
    end

    always_comb begin
        int idx;
        idx         = 0;
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            idx = rr_index(int'(rr_ptr_q), k, NUM_FU);
            if (!grant_valid && !fifo_empty[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = PTR_W'(idx);
            end
        end
    end

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        cdb_valid_d = grant_valid && !squash;
        cdb_entry_d = cdb_entry_q;
        if (squash) begin
            rr_ptr_d = '0;
        end else if (grant_valid) begin
            rr_ptr_d    = (grant_idx == PTR_W'(NUM_FU - 1)) ? '0 : grant_idx + PTR_W'(1);
            cdb_entry_d = fifo_head[grant_idx];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rr_ptr_q    <= '0;
            cdb_valid_q <= 1'b0;
            cdb_entry_q <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_entry_q <= cdb_entry_d;
        end
    end

    assign cdb_valid       = cdb_valid_q;
    assign cdb_tag         = cdb_entry_q.tag;
    assign cdb_value       = cdb_entry_q.value;
    assign cdb_take_branch = cdb_entry_q.take_branch;

`ifdef CDB_ARB_STATS_EN
    logic [31:0] conflict_q, conflict_d;
    logic        conflict_now;

    assign conflict_now = ($countones(~fifo_empty) > 1) || (|(fu_valid & ~fu_ready));

    always_comb begin
        conflict_d = conflict_q;
        if (conflict_now && (conflict_q != '1)) conflict_d = conflict_q + 32'd1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) conflict_q <= '0;
        else        conflict_q <= conflict_d;
    end

    assign conflict_cycles = conflict_q;
`endif

endmodule

// File: tb/tb_cdb_broadcast_arbiter.sv
// tb/tb_cdb_broadcast_arbiter.sv - directed self-checking bench for cdb_broadcast_arbiter
module tb_cdb_broadcast_arbiter;

    logic         clock = 1'b0;
    logic         reset;
    logic         squash;
    logic [3:0]   fu_valid;
    logic [19:0]  fu_tag;
    logic [127:0] fu_value;
    logic [3:0]   fu_take_branch;
    logic [3:0]   fu_ready;
    logic         cdb_valid;
    logic [4:0]   cdb_tag;
    logic [31:0]  cdb_value;
    logic         cdb_take_branch;

    int checks = 0;
    int errors = 0;
    int seq [4];

    cdb_broadcast_arbiter dut (
        .clock           (clock),
        .reset           (reset),
        .squash          (squash),
        .fu_valid        (fu_valid),
        .fu_tag          (fu_tag),
        .fu_value        (fu_value),
        .fu_take_branch  (fu_take_branch),
        .fu_ready        (fu_ready),
        .cdb_valid       (cdb_valid),
        .cdb_tag         (cdb_tag),
        .cdb_value       (cdb_value),
        .cdb_take_branch (cdb_take_branch)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // Advance one edge; an FU result counts as accepted if valid&ready held just before the edge
    task automatic tick();
        logic [3:0] acc;
        acc = fu_valid & fu_ready;
        @(posedge clock);
        #1;
        for (int i = 0; i < 4; i++) if (acc[i]) seq[i]++;
    endtask

    task automatic set_fu(input int i, input logic v, input logic [4:0] t,
                          input logic [31:0] val, input logic tb);
        fu_valid[i]            = v;
        fu_tag[i*5 +: 5]       = t;
        fu_value[i*32 +: 32]   = val;
        fu_take_branch[i]      = tb;
    endtask

    task automatic flood_drive();
        logic [4:0] t;
        for (int i = 0; i < 4; i++) begin
            t = 5'(i * 8 + seq[i]);
            set_fu(i, 1'b1, t, 32'hA000_0000 | 32'(t), 1'b0);
        end
    endtask

    initial begin
        logic [4:0] exp_tag;
        int b;
        reset = 1'b0; squash = 1'b0;
        fu_valid = '0; fu_tag = '0; fu_value = '0; fu_take_branch = '0;
        for (int i = 0; i < 4; i++) seq[i] = 0;
        #2;
        chk("reset_valid", 32'(cdb_valid), 32'd0);
        chk("reset_tag",   32'(cdb_tag),   32'd0);
        chk("reset_value", cdb_value,      32'd0);
        chk("reset_taken", 32'(cdb_take_branch), 32'd0);
        tick(); tick();
        #5 reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("idle_valid", 32'(cdb_valid), 32'd0);
            chk("idle_ready", 32'(fu_ready),  32'hF);
        end

        set_fu(2, 1'b1, 5'd7, 32'hDEAD_BEEF, 1'b1);
        tick();
        set_fu(2, 1'b0, 5'd0, 32'd0, 1'b0);
        chk("single_no_bypass", 32'(cdb_valid), 32'd0);
        tick();
        chk("single_valid", 32'(cdb_valid), 32'd1);
        chk("single_tag",   32'(cdb_tag),   32'd7);
        chk("single_value", cdb_value,      32'hDEAD_BEEF);
        chk("single_taken", 32'(cdb_take_branch), 32'd1);
        tick();
        chk("single_after_valid", 32'(cdb_valid), 32'd0);
        chk("single_hold_tag",    32'(cdb_tag),   32'd7);
        chk("single_hold_value",  cdb_value,      32'hDEAD_BEEF);

        squash = 1'b1;
        tick();
        squash = 1'b0;
        chk("pre_flood_squash_valid", 32'(cdb_valid), 32'd0);

        // Fairness and backpressure: every FU floods; broadcast k must be FU k%4, its (k/4)-th result
        for (int i = 0; i < 4; i++) seq[i] = 0;
        flood_drive();
        for (int k = 0; k < 16; k++) begin
            tick();
            flood_drive();
            if (k == 2) chk("bp_ready", 32'(fu_ready), 32'h2);
            if (k >= 1) begin
                b = k - 1;
                exp_tag = 5'((b % 4) * 8 + b / 4);
                chk("flood_valid", 32'(cdb_valid), 32'd1);
                chk("flood_tag",   32'(cdb_tag),   32'(exp_tag));
                chk("flood_value", cdb_value,      32'hA000_0000 | 32'(exp_tag));
            end
        end

        fu_valid = '0;
        set_fu(1, 1'b1, 5'd11, 32'h1111, 1'b0);
        squash = 1'b1;
        tick();
        squash = 1'b0;
        set_fu(1, 1'b0, 5'd0, 32'd0, 1'b0);
        chk("squash_valid", 32'(cdb_valid), 32'd0);
        set_fu(0, 1'b1, 5'd3,  32'h33,   1'b1);
        set_fu(3, 1'b1, 5'd30, 32'h3030, 1'b0);
        tick();
        fu_valid = '0;
        chk("post_squash_latency", 32'(cdb_valid), 32'd0);
        tick();
        chk("post_squash_first_valid", 32'(cdb_valid), 32'd1);
        chk("post_squash_first_tag",   32'(cdb_tag),   32'd3);
        chk("post_squash_first_taken", 32'(cdb_take_branch), 32'd1);
        tick();
        chk("post_squash_second_tag",   32'(cdb_tag),   32'd30);
        chk("post_squash_second_value", cdb_value,      32'h3030);
        tick();
        chk("post_squash_drained", 32'(cdb_valid), 32'd0);
        tick();
        chk("squash_dropped_enq", 32'(cdb_valid), 32'd0);

        set_fu(1, 1'b1, 5'd5, 32'h55, 1'b0);
        set_fu(2, 1'b1, 5'd6, 32'h66, 1'b0);
        tick();
        fu_valid = '0;
        tick();
        chk("pre_reset_valid", 32'(cdb_valid), 32'd1);
        chk("pre_reset_tag",   32'(cdb_tag),   32'd5);
        #3 reset = 1'b0;
        #1;
        chk("async_reset_valid", 32'(cdb_valid), 32'd0);
        chk("async_reset_tag",   32'(cdb_tag),   32'd0);
        chk("async_reset_value", cdb_value,      32'd0);
        #2 reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("post_reset_valid", 32'(cdb_valid), 32'd0);
        end
        chk("post_reset_ready", 32'(fu_ready), 32'hF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cdb_broadcast_arbiter.md
Name: cdb_broadcast_arbiter

Overview:
- Complete-stage block on the producer side of the common data bus.
- Collects finished results from NUM_FU functional units and buffers them in per-unit FIFOs.
- Grants one result per cycle by round-robin and drives a registered CDB broadcast.
- The dispatch/issue stage (RS, ROB, map table) consumes that broadcast for wakeup, tag clear and completion marking.

Parameters:
- NUM_FU, 4, number of functional-unit result ports.
- BUF_DEPTH, 2, entries per FU result FIFO (power of two, ≥ 2).
- TAG_W, 5, ROB index width carried on the CDB.
- DATA_W, 32, result value width.

Ports:
- clock  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- squash  in  1  ROB branch-mispredict flush, synchronous.
- fu_valid  in  NUM_FU  per-FU result valid.
- fu_tag  in  NUM_FU*TAG_W  per-FU ROB tag, FU i at bits [i*TAG_W +: TAG_W].
- fu_value  in  NUM_FU*DATA_W  per-FU result value.
- fu_take_branch  in  NUM_FU  per-FU resolved-taken flag.
- fu_ready  out  NUM_FU  per-FU accept; FU may hold a result until ready.
- cdb_valid  out  1  broadcast valid.
- cdb_tag  out  TAG_W  broadcast ROB tag.
- cdb_value  out  DATA_W  broadcast value.
- cdb_take_branch  out  1  broadcast taken flag.

Behaviour:
- Reset (reset = 0, asynchronous):
  - All FIFOs empty; round-robin pointer = 0.
  - cdb_valid = 0, cdb_tag = 0, cdb_value = 0, cdb_take_branch = 0.
  - fu_ready = all ones once reset deasserts.
- Enqueue:
  - FU i enqueues when fu_valid[i] && fu_ready[i] at the clock edge.
  - fu_ready[i] = (count_i < BUF_DEPTH), derived only from registered count.
  - No dependence on same-cycle dequeue; no combinational path from grant to fu_ready.
- Arbitration:
  - Combinational round-robin over non-empty FIFOs.
  - Search starts at the pointer and wraps modulo NUM_FU.
  - The winner's head is dequeued at the edge; the pointer moves to (winner+1) mod NUM_FU.
  - With no non-empty FIFO, the pointer holds.
- Broadcast:
  - The winner's head is registered into the cdb_* outputs.
  - Latency is 1 cycle: a result enqueued at edge t is broadcast in cycle t+1 at the earliest.
  - No FU-to-CDB bypass. Exactly one broadcast per cycle.
  - cdb_valid = 0 in any cycle following an edge with no winner; the other cdb_* fields then hold their previous values.
- Simultaneous enqueue and dequeue on the same FIFO: count unchanged, order preserved, and a full FIFO stays full.
- Wrap-around: read/write pointers are log2(BUF_DEPTH) bits and wrap naturally; full/empty come from a separate count of width log2(BUF_DEPTH)+1.
- Squash (squash = 1 at an edge):
  - All FIFOs are emptied; enqueues in that cycle are dropped.
  - cdb_valid = 0 in the following cycle; the pointer resets to 0.
  - A broadcast already registered in the squash cycle remains visible during that cycle.
- Reset asserted mid-operation: all state clears immediately, without waiting for a clock edge.

Optional Feature:
- Macro: CDB_ARB_STATS_EN.
- When defined:
  - Adds output port conflict_cycles, 32 bits.
  - It is a saturating counter that increments each cycle in which two or more FIFOs are non-empty, or any fu_valid[i] is high while fu_ready[i] = 0.
  - It is cleared by reset; squash does not clear it.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package:
  - CDB entry struct {tag, value, take_branch}, matching the existing CDB_PACKET field order.
  - NUM_FU and the ROB tag width constant.
- Sub-module cdb_result_fifo: one instance per FU.
  - Inputs: push, pop, flush, data in.
  - Outputs: head, empty, full.
- The top level holds the round-robin arbiter and the output register.

Test Plan:
- Reset release, idle: all fu_valid = 0 → cdb_valid = 0 indefinitely, fu_ready = 4'b1111.
- Single result: FU2 presents tag 5'd7, value 32'hDEAD_BEEF, taken 1 at edge t → cycle t+1 shows cdb_valid = 1, tag 7, value DEADBEEF, take_branch 1; cycle t+2 shows cdb_valid = 0.
- Fairness:
  - Stimulus: all four FUs present results every cycle for 8 cycles.
  - Required: broadcast order by FU is 0,1,2,3,0,1,2,3; no FU is starved.
- Backpressure: FU0 valid every cycle while FU1..3 also flood → fu_ready[0] drops to 0 once its 2 entries fill; no FU0 result is lost or duplicated (check the tag sequence 0..N in order).
- Squash: 3 FIFOs holding results when squash is pulsed at edge t → cdb_valid = 0 from t+1; new results from t+1 are broadcast normally starting with FU0 priority.
- Async reset mid-stream: drop reset while cdb_valid = 1 → cdb_valid = 0 without a clock edge; no pre-reset entry appears after release.
